// File: rtl/video_pkg.sv
// Shared definitions for the video output path: line-fetch FSM states,
// display mode constants used by the video controller, and a burst-length helper.
package video_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_DATA
    } fetch_state_t;

    // 1024x768 mode: active area and full frame totals including blanking.
    localparam int H_ACTIVE = 1024;
    localparam int V_ACTIVE = 768;
    localparam int H_TOTAL  = 1344;
    localparam int V_TOTAL  = 806;

    // Beats to request next: whatever is left of the line, capped at one burst.
    function automatic int burst_min(input int remaining, input int burst_len);
        return (remaining < burst_len) ? remaining : burst_len;
    endfunction

endpackage

// File: rtl/video_line_fetcher.sv
// Scanline prefetch scheduler: turns a line request into a sequence of
// single-outstanding burst reads and writes the returned words into one
// bank of a two-bank line buffer while the display side reads the other.
module video_line_fetcher
    import video_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LB_WORDS   = H_ACTIVE,
    parameter int BURST_LEN  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [ADDR_WIDTH-1:0]        fb_base,
    input  logic [ADDR_WIDTH-1:0]        line_stride,
    input  logic [$clog2(LB_WORDS):0]    line_words,
    input  logic                         frame_start,
    input  logic                         line_req,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic [ADDR_WIDTH-1:0]        mem_req_addr,
    output logic [$clog2(BURST_LEN):0]   mem_req_len,
    input  logic                         mem_rdata_valid,
    input  logic [DATA_WIDTH-1:0]        mem_rdata,
    output logic                         lb_we,
    output logic [$clog2(LB_WORDS):0]    lb_waddr,
    output logic [DATA_WIDTH-1:0]        lb_wdata,
    output logic                         line_done,
    output logic                         line_bank,
    output logic                         busy,
    output logic                         underrun,
    input  logic                         underrun_clr
);

    localparam int IDX_W          = $clog2(LB_WORDS);
    localparam int LW_W           = IDX_W + 1;
    localparam int LEN_W          = $clog2(BURST_LEN) + 1;
    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;

    fetch_state_t            state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [ADDR_WIDTH-1:0]   next_line_addr_reg;
    logic [LW_W-1:0]         remaining_reg;
    logic [LEN_W-1:0]        beats_left_reg;
    logic [IDX_W-1:0]        word_idx_reg;
    logic                    fill_bank_reg;
    logic                    cur_bank_reg;
    logic                    lb_we_reg;
    logic [LW_W-1:0]         lb_waddr_reg;
    logic [DATA_WIDTH-1:0]   lb_wdata_reg;
    logic                    line_done_reg;
    logic                    line_bank_reg;
    logic                    underrun_reg;

    logic                    accept;
    logic                    zero_line;
    logic                    handshake;
    logic                    beat;
    logic                    last_beat;
    logic [LW_W-1:0]         words_clamped;
    logic [LEN_W-1:0]        req_len;
    logic [ADDR_WIDTH-1:0]   line_base;
    logic                    bank_sel;

    // A frame start in the same cycle as a line request takes effect first.
    assign words_clamped = (line_words > LW_W'(LB_WORDS)) ? LW_W'(LB_WORDS) : line_words;
    assign req_len       = LEN_W'(burst_min(int'(remaining_reg), BURST_LEN));
    assign line_base     = frame_start ? fb_base : next_line_addr_reg;
    assign bank_sel      = frame_start ? 1'b0 : fill_bank_reg;

    assign busy          = (state_reg != FETCH_IDLE);
    assign mem_req_valid = (state_reg == FETCH_REQ);
    assign mem_req_addr  = addr_reg;
    assign mem_req_len   = req_len;
    assign lb_we         = lb_we_reg;
    assign lb_waddr      = lb_waddr_reg;
    assign lb_wdata      = lb_wdata_reg;
    assign line_done     = line_done_reg;
    assign line_bank     = line_bank_reg;
    assign underrun      = underrun_reg;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= FETCH_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and per-cycle event strobes for the datapath.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        zero_line  = 1'b0;
        handshake  = 1'b0;
        beat       = 1'b0;
        last_beat  = 1'b0;
        case (state_reg)
            FETCH_IDLE: begin
                if (line_req && enable) begin
                    accept = 1'b1;
                    if (words_clamped == '0) begin
                        zero_line = 1'b1;
                    end else begin
                        state_next = FETCH_REQ;
                    end
                end
            end
            FETCH_REQ: begin
                if (mem_req_ready) begin
                    handshake  = 1'b1;
                    state_next = FETCH_DATA;
                end
            end
            FETCH_DATA: begin
                if (mem_rdata_valid) begin
                    beat = 1'b1;
                    if (beats_left_reg == LEN_W'(1)) begin
                        last_beat  = 1'b1;
                        state_next = (remaining_reg != '0) ? FETCH_REQ : FETCH_IDLE;
                    end
                end
            end
            default: state_next = FETCH_IDLE;
        endcase
    end

    // Address, counters, bank bookkeeping and registered line-buffer/status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg           <= '0;
            next_line_addr_reg <= '0;
            remaining_reg      <= '0;
            beats_left_reg     <= '0;
            word_idx_reg       <= '0;
            fill_bank_reg      <= 1'b0;
            cur_bank_reg       <= 1'b0;
            lb_we_reg          <= 1'b0;
            lb_waddr_reg       <= '0;
            lb_wdata_reg       <= '0;
            line_done_reg      <= 1'b0;
            line_bank_reg      <= 1'b0;
            underrun_reg       <= 1'b0;
        end else begin
            lb_we_reg     <= 1'b0;
            line_done_reg <= 1'b0;

            // Every request, accepted or dropped, advances the line pointer so
            // later lines stay aligned with the display.
            if (line_req && (busy || enable)) begin
                next_line_addr_reg <= line_base + line_stride;
            end else if (frame_start) begin
                next_line_addr_reg <= fb_base;
            end

            // The bank is claimed when the line is accepted, so a frame start
            // during a fetch redirects only the next line.
            if (accept) begin
                fill_bank_reg <= ~bank_sel;
                cur_bank_reg  <= bank_sel;
                addr_reg      <= line_base;
                remaining_reg <= words_clamped;
                word_idx_reg  <= '0;
            end else if (frame_start) begin
                fill_bank_reg <= 1'b0;
            end

            // The request address is only observed in REQ, so advance it at the handshake.
            if (handshake) begin
                beats_left_reg <= req_len;
                remaining_reg  <= remaining_reg - LW_W'(req_len);
                addr_reg       <= addr_reg + ADDR_WIDTH'(int'(req_len) * BYTES_PER_WORD);
            end else if (beat) begin
                beats_left_reg <= beats_left_reg - LEN_W'(1);
            end

            if (beat) begin
                lb_we_reg    <= 1'b1;
                lb_waddr_reg <= {cur_bank_reg, word_idx_reg};
                lb_wdata_reg <= mem_rdata;
                word_idx_reg <= word_idx_reg + IDX_W'(1);
            end

            if (zero_line) begin
                line_done_reg <= 1'b1;
                line_bank_reg <= bank_sel;
            end else if (last_beat && (remaining_reg == '0)) begin
                line_done_reg <= 1'b1;
                line_bank_reg <= cur_bank_reg;
            end

            if (line_req && busy) begin
                underrun_reg <= 1'b1;
            end else if (underrun_clr) begin
                underrun_reg <= 1'b0;
            end
        end
    end

endmodule
